// File: rtl/life_gen_ctrl.sv
// rtl/life_gen_ctrl.sv - run/pause/step/clear generation sequencer; optional macro LIFE_AUTO_STOP_EN
module life_gen_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int PER_W       = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_raw,
    input  logic             pause_raw,
    input  logic             step_raw,
    input  logic             clear_raw,
    input  logic [PER_W-1:0] period,
`ifdef LIFE_AUTO_STOP_EN
    input  logic             board_changed,
    output logic             stable,
`endif
    output logic             gen_en,
    output logic             clear_en,
    output logic             running,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] gen_count
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    // Button bit order inside the synchroniser: {clear, pause, start, step}
    logic [3:0]       raw_vec;
    logic [3:0]       sync_q [SYNC_STAGES];
    logic [3:0]       hist_q;
    logic [3:0]       rise;
    logic             act_clear;
    logic             act_pause;
    logic             act_start;
    logic             act_step;
    logic             auto_stop;

    logic [PER_W-1:0] tick_q;
    logic [PER_W-1:0] tick_next;
    logic [PER_W-1:0] period_m1;
    logic [1:0]       state_next;
    logic             gen_next;
    logic             clr_next;
    logic [CNT_W-1:0] count_next;
    logic             stable_q;
    logic             stable_next;

    assign raw_vec = {clear_raw, pause_raw, start_raw, step_raw};

    // Synchronise the raw buttons and keep one cycle of history for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= raw_vec;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Only the highest-priority edge acts: clear > pause > start > step
    assign act_clear = rise[3];
    assign act_pause = rise[2] & ~rise[3];
    assign act_start = rise[1] & ~(|rise[3:2]);
    assign act_step  = rise[0] & ~(|rise[3:1]);

    // Period of zero behaves like a period of one
    assign period_m1 = (period == '0) ? '0 : period - PER_W'(1);

`ifdef LIFE_AUTO_STOP_EN
    logic gen_d_q;

    // Remember that the board was asked to advance last cycle, so board_changed is meaningful now
    always_ff @(posedge clock) begin
        if (reset) begin
            gen_d_q <= 1'b0;
        end else begin
            gen_d_q <= gen_en;
        end
    end

    assign auto_stop = gen_d_q & ~board_changed;
    assign stable    = stable_q;
`else
    assign auto_stop = 1'b0;
`endif

    // Next-state, tick and pulse decisions for the sequencer
    always_comb begin
        state_next  = state;
        tick_next   = tick_q;
        gen_next    = 1'b0;
        clr_next    = 1'b0;
        stable_next = stable_q;
        if (act_clear) begin
            clr_next    = 1'b1;
            state_next  = ST_IDLE;
            tick_next   = '0;
            stable_next = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (act_start) begin
                        state_next  = ST_RUN;
                        tick_next   = '0;
                        stable_next = 1'b0;
                    end else if (act_step) begin
                        gen_next    = 1'b1;
                        stable_next = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (act_pause) begin
                        state_next = ST_PAUSE;
                    end else if (auto_stop) begin
                        state_next  = ST_PAUSE;
                        stable_next = 1'b1;
                    end else if (tick_q >= period_m1) begin
                        // >= so a shortened period fires immediately instead of wrapping
                        gen_next  = 1'b1;
                        tick_next = '0;
                    end else begin
                        tick_next = tick_q + PER_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (act_start) begin
                        state_next  = ST_RUN;
                        tick_next   = '0;
                        stable_next = 1'b0;
                    end else if (act_step) begin
                        gen_next    = 1'b1;
                        stable_next = 1'b0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    tick_next  = '0;
                end
            endcase
        end
    end

    // Generation counter follows the registered gen pulse and saturates
    always_comb begin
        count_next = gen_count;
        if (clr_next) begin
            count_next = '0;
        end else if (gen_next && (gen_count != '1)) begin
            count_next = gen_count + CNT_W'(1);
        end
    end

    // Register state, pulses and counters together so running tracks state exactly
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            tick_q    <= '0;
            gen_en    <= 1'b0;
            clear_en  <= 1'b0;
            running   <= 1'b0;
            gen_count <= '0;
            stable_q  <= 1'b0;
        end else begin
            state     <= state_next;
            tick_q    <= tick_next;
            gen_en    <= gen_next;
            clear_en  <= clr_next;
            running   <= (state_next == ST_RUN);
            gen_count <= count_next;
            stable_q  <= stable_next;
        end
    end

endmodule
